full_adder_unit: RTL and testbench
==================================

Name: full_adder_unit

Overview:
- Single-bit (parameterisable-width) binary full adder with a registered output stage.
- Used as the arithmetic leaf cell in the datapath; at WIDTH=1 its function equals a classic 1-bit full adder.
- Computes {o_Cout, o_s} = i_a + i_b + i_Cin and presents the result one clock after capture, with a valid flag.

Parameters:
- WIDTH, 1, operand width in bits; ripple-carry chain of WIDTH full-adder cells.
- OUT_REG, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational (clock/reset affect o_valid only).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  qualifies i_a/i_b/i_Cin this cycle.
- i_a  input  WIDTH  addend A (unsigned).
- i_b  input  WIDTH  addend B (unsigned).
- i_Cin  input  1  carry-in into bit 0.
- o_s  output  WIDTH  sum bits.
- o_Cout  output  1  carry-out of MSB.
- o_valid  output  1  o_s/o_Cout hold a valid result.

Behaviour:
- Per cell k: s[k] = a[k] XOR b[k] XOR c[k]; c[k+1] = a[k]b[k] | a[k]c[k] | b[k]c[k]; c[0] = i_Cin; o_Cout = c[WIDTH].
- Arithmetic: unsigned, result width WIDTH+1; {o_Cout,o_s} = i_a + i_b + i_Cin exactly, no saturation; overflow is reported only via o_Cout (wrap-around in o_s).
- OUT_REG=1: on each rising i_clk edge with i_rst=0 and i_valid=1, o_s/o_Cout load the combinational result; o_valid <= 1. Latency exactly 1 cycle.
- OUT_REG=1, i_valid=0: o_s/o_Cout hold previous value; o_valid <= 0.
- Back-to-back i_valid: a new result every cycle, full throughput, no stalls, no backpressure.
- Reset (i_rst=1 at a rising edge): o_s = 0, o_Cout = 0, o_valid = 0; reset overrides i_valid. Reset mid-stream discards the in-flight result; first valid output reappears 1 cycle after the first valid input following reset deassertion.
- OUT_REG=0: o_s/o_Cout combinational from inputs at all times (reset does not mask them); o_valid = i_valid & ~i_rst combinationally.
- No X propagation requirements beyond standard: all registers reset; no latches; no internal state besides output registers.

Decomposition:
- Shared package: none required; WIDTH default and any adder constants stay local parameters.
- Sub-module: full_adder_cell (pure combinational 1-bit a, b, cin -> s, cout), instantiated WIDTH times via generate in full_adder_unit; output/valid registers live in the top.

Test Plan:
- WIDTH=1, OUT_REG=1, i_valid=1: drive {i_a,i_b,i_Cin} counting 000..111, one value per cycle -> one cycle later {o_Cout,o_s} = 00,01,01,10,01,10,10,11; o_valid=1 throughout.
- WIDTH=1, hold i_rst=1 for 3 cycles with inputs 1,1,1 -> o_s=0, o_Cout=0, o_valid=0; release -> next cycle o_s=1, o_Cout=1, o_valid=1.
- WIDTH=4: i_a=4'hF, i_b=4'h1, i_Cin=0 -> o_s=4'h0, o_Cout=1; i_a=4'h7, i_b=4'h8, i_Cin=1 -> o_s=4'h0, o_Cout=1; i_a=4'h3, i_b=4'h4, i_Cin=0 -> o_s=4'h7, o_Cout=0.
- i_valid pulse: valid with 1+1+0 (WIDTH=1) then i_valid=0 with inputs changed to 0,0,0 -> o_s=0, o_Cout=1 held, o_valid drops to 0 on following cycle.
- Reset mid-stream: i_rst asserted the cycle after a valid input 1,0,1 -> outputs 0/0, o_valid=0; no stale result emitted.
- OUT_REG=0, WIDTH=1: inputs 1,1,0 -> o_s=0, o_Cout=1 in the same cycle, o_valid tracks i_valid.

Source files
------------

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit combinational full adder leaf cell
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/full_adder_unit.sv
// rtl/full_adder_unit.sv - ripple-carry adder of WIDTH cells with optional output register
module full_adder_unit #(
    parameter int WIDTH   = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_Cin,
    output logic [WIDTH-1:0] o_s,
    output logic             o_Cout,
    output logic             o_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = i_Cin;

    for (genvar k = 0; k < WIDTH; k++) begin : g_cell
        full_adder_cell u_cell (
            .a_i   (i_a[k]),
            .b_i   (i_b[k]),
            .cin_i (carry[k]),
            .s_o   (sum[k]),
            .cout_o(carry[k+1])
        );
    end

    if (OUT_REG) begin : g_reg
        logic [WIDTH-1:0] s_q, s_d;
        logic             cout_q, cout_d;
        logic             valid_q, valid_d;

        // Result registers hold through idle cycles; only the valid flag drops.
        always_comb begin
            s_d     = s_q;
            cout_d  = cout_q;
            valid_d = i_valid;
            if (i_valid) begin
                s_d    = sum;
                cout_d = carry[WIDTH];
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s_q     <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                s_q     <= s_d;
                cout_q  <= cout_d;
                valid_q <= valid_d;
            end
        end

        assign o_s     = s_q;
        assign o_Cout  = cout_q;
        assign o_valid = valid_q;
    end else begin : g_comb
        assign o_s     = sum;
        assign o_Cout  = carry[WIDTH];
        assign o_valid = i_valid & ~i_rst;
    end

endmodule

// File: tb/tb_full_adder_unit.sv
// tb/tb_full_adder_unit.sv - self-checking bench for full_adder_unit
module tb_full_adder_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the WIDTH=1 registered and combinational instances
    logic       rst1, valid1, a1, b1, c1;
    logic       s1, co1, v1;
    logic       s0, co0, v0;
    // WIDTH=4 registered instance
    logic       rst4, valid4, c4;
    logic [3:0] a4, b4, s4;
    logic       co4, v4;

    int checks = 0;
    int errors = 0;

    full_adder_unit #(.WIDTH(1), .OUT_REG(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_valid(valid1), .i_a(a1), .i_b(b1), .i_Cin(c1),
        .o_s(s1), .o_Cout(co1), .o_valid(v1)
    );

    full_adder_unit #(.WIDTH(1), .OUT_REG(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst1), .i_valid(valid1), .i_a(a1), .i_b(b1), .i_Cin(c1),
        .o_s(s0), .o_Cout(co0), .o_valid(v0)
    );

    full_adder_unit #(.WIDTH(4), .OUT_REG(1'b1)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_valid(valid4), .i_a(a4), .i_b(b4), .i_Cin(c4),
        .o_s(s4), .o_Cout(co4), .o_valid(v4)
    );

    typedef struct {
        logic       a, b, c;
        logic [1:0] exp;
    } vec1_t;

    typedef struct {
        logic [3:0] a, b;
        logic       c;
        logic [4:0] exp;
    } vec4_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the WIDTH=1 pair, check the combinational instance before the edge,
    // then advance one clock so the registered result is visible.
    task automatic apply1(input logic a, input logic b, input logic c,
                          input logic v, input logic r);
        logic [1:0] total;
        a1 = a; b1 = b; c1 = c; valid1 = v; rst1 = r;
        total = 2'(a) + 2'(b) + 2'(c);
        #1;
        chk("comb_sum", {co0, s0}, total);
        chk("comb_valid", v0, v & ~r);
        @(posedge clk); #1;
    endtask

    task automatic step4();
        @(posedge clk); #1;
    endtask

    task automatic chk1(input string name, input logic s, input logic co, input logic v);
        chk({name, "_sum"}, {co1, s1}, {co, s});
        chk({name, "_valid"}, v1, v);
    endtask

    vec1_t tab1[8];
    vec4_t tab4[3];
    logic [4:0] m_res;
    logic       m_valid;

    initial begin
        tab1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        tab1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        tab1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        tab1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        tab1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        tab1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        tab1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        tab1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};
        tab4[0] = '{4'hF, 4'h1, 1'b0, 5'h10};
        tab4[1] = '{4'h7, 4'h8, 1'b1, 5'h10};
        tab4[2] = '{4'h3, 4'h4, 1'b0, 5'h07};

        rst1 = 1'b1; valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        rst4 = 1'b1; valid4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk1("reset", 1'b0, 1'b0, 1'b0);
        chk("reset4_sum", {co4, s4}, 5'h00);
        chk("reset4_valid", v4, 1'b0);

        // Exhaustive 1-bit truth table, back-to-back
        for (int i = 0; i < 8; i++) begin
            apply1(tab1[i].a, tab1[i].b, tab1[i].c, 1'b1, 1'b0);
            chk1("truth", tab1[i].exp[0], tab1[i].exp[1], 1'b1);
        end

        // Reset held three cycles with 1,1,1 driven
        for (int i = 0; i < 3; i++) begin
            apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            chk1("rst_hold", 1'b0, 1'b0, 1'b0);
        end
        apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk1("rst_release", 1'b1, 1'b1, 1'b1);

        // Valid pulse then idle: result holds, valid drops
        apply1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk1("pulse", 1'b0, 1'b1, 1'b1);
        apply1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk1("pulse_hold", 1'b0, 1'b1, 1'b0);

        // Reset the cycle after a valid input
        apply1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk1("mid_pre", 1'b0, 1'b1, 1'b1);
        apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk1("mid_rst", 1'b0, 1'b0, 1'b0);
        apply1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk1("mid_idle", 1'b0, 1'b0, 1'b0);
        apply1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk1("mid_resume", 1'b1, 1'b0, 1'b1);

        // WIDTH=4 directed carry cases, back-to-back
        rst4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4 = tab4[i].a; b4 = tab4[i].b; c4 = tab4[i].c; valid4 = 1'b1;
            step4();
            chk("w4_sum", {co4, s4}, tab4[i].exp);
            chk("w4_valid", v4, 1'b1);
        end

        // Random WIDTH=4 traffic against an arithmetic reference
        m_res   = 5'h07;
        m_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            c4     = 1'($urandom);
            valid4 = ($urandom_range(0, 3) != 0);
            rst4   = ($urandom_range(0, 19) == 0);
            if (rst4) begin
                m_res = 5'h00; m_valid = 1'b0;
            end else if (valid4) begin
                m_res = 5'(a4) + 5'(b4) + 5'(c4); m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            step4();
            chk("rand_sum", {co4, s4}, m_res);
            chk("rand_valid", v4, m_valid);
        end

        // Random combinational checks on the OUT_REG=0 instance
        for (int i = 0; i < 50; i++) begin
            apply1(1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
